// File: rtl/data_bus_defs.sv
// data_bus_defs: shared bus mode constants, arbiter FSM encoding and mode legality helper
package data_bus_defs;
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  function automatic logic legal_mode(input logic [1:0] m);
    return m == BUS_READ || m == BUS_WRITE;
  endfunction
endpackage

// File: rtl/rr_lock_picker.sv
// rr_lock_picker: combinational round-robin winner selection honouring an exclusive lock owner
module rr_lock_picker (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_lock_vld,
  input  logic       i_lock_own,
  output logic       o_valid,
  output logic       o_winner
);
  always_comb begin
    o_valid  = i_lock_vld ? i_req[i_lock_own] : |i_req;
    o_winner = i_lock_vld ? i_lock_own : (&i_req ? ~i_last : i_req[1]);
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-master round-robin arbiter with lock/timeout, sequencing IDLE->BUS->DONE bus cycles
module data_bus_arbiter
  import data_bus_defs::*;
#(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [1:0]  m0_mode,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [1:0]  m1_mode,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [1:0]  grant,
  inout  wire  [31:0] data_bus_data,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  state_t r_state, w_state_nxt;
  logic r_winner, r_last, r_lock_vld, r_lock_own, r_err;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_bus_mode, w_sel_mode;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata0, r_rdata1, w_sel_addr, w_sel_rd;
  logic w_valid, w_pick, w_legal, w_win_lock, w_own_idle, w_timeout;
  rr_lock_picker u_picker (
    .i_req     ({m1_req, m0_req}),
    .i_last    (r_last),
    .i_lock_vld(r_lock_vld),
    .i_lock_own(r_lock_own),
    .o_valid   (w_valid),
    .o_winner  (w_pick)
  );
  always_comb begin
    w_sel_mode  = w_pick ? m1_mode : m0_mode;
    w_sel_addr  = w_pick ? m1_addr : m0_addr;
    w_legal     = legal_mode(w_sel_mode);
    w_win_lock  = r_winner ? m1_lock : m0_lock;
    w_own_idle  = r_lock_vld && !(r_lock_own ? m1_req : m0_req);
    w_cnt_nxt   = r_cnt + CW'(1);
    w_timeout   = w_cnt_nxt == CW'(LOCK_TIMEOUT);
    w_sel_rd    = r_bus_mode == BUS_READ ? data_bus_data : '0;
    w_state_nxt = r_state == IDLE ? (w_valid ? BUS : IDLE) : (r_state == BUS ? DONE : IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // Illegal modes keep the bus registers idle; only the err flag records them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_winner    <= 1'b0;
      r_err       <= 1'b0;
      r_bus_mode  <= BUS_IDLE;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_winner    <= w_pick;
      r_err       <= !w_legal;
      r_bus_mode  <= w_legal ? w_sel_mode : BUS_IDLE;
      r_bus_addr  <= w_legal ? w_sel_addr : '0;
      r_bus_wdata <= w_pick ? m1_wdata : m0_wdata;
    end else if (r_state == BUS) begin
      r_bus_mode  <= BUS_IDLE;
      r_bus_addr  <= '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == BUS) begin
      r_rdata0 <= r_winner ? r_rdata0 : w_sel_rd;
      r_rdata1 <= r_winner ? w_sel_rd : r_rdata1;
    end
  end
  // Lock ownership follows the completing master; an idle owner loses it after LOCK_TIMEOUT cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_lock_vld <= 1'b0;
      r_lock_own <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == DONE) begin
      r_last     <= r_winner;
      r_lock_vld <= w_win_lock;
      r_lock_own <= r_winner;
      r_cnt      <= '0;
    end else if (r_state == IDLE && w_own_idle) begin
      r_lock_vld <= !w_timeout;
      r_cnt      <= w_timeout ? '0 : w_cnt_nxt;
    end else if (r_state == IDLE && w_valid) begin
      r_cnt      <= '0;
    end
  end
  assign grant         = r_state == IDLE ? 2'b00 : {r_winner, ~r_winner};
  assign data_bus_mode = r_bus_mode;
  assign data_bus_addr = r_bus_addr;
  assign data_bus_data = (r_state == BUS && r_bus_mode == BUS_WRITE) ? r_bus_wdata : 'z;
  assign m0_ack        = r_state == DONE && !r_winner;
  assign m1_ack        = r_state == DONE && r_winner;
  assign m0_err        = m0_ack && r_err;
  assign m1_err        = m1_ack && r_err;
  assign m0_rdata      = r_rdata0;
  assign m1_rdata      = r_rdata1;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: scoreboard bench with a small memory slave on the shared bus
module tb_data_bus_arbiter;
  typedef struct {logic err; logic [31:0] rdata; int cyc; int prev;} exp_t;
  typedef struct {logic [1:0] mode; logic [31:0] addr; logic [31:0] data;} bus_t;
  logic clk, reset, clr;
  logic m0_req, m0_lock, m1_req, m1_lock;
  logic [1:0] m0_mode, m1_mode;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [1:0] grant;
  wire [31:0] data_bus_data;
  logic [31:0] data_bus_addr;
  logic [1:0] data_bus_mode;
  logic [31:0] mem [16];
  logic [15:0] wr_flag;
  logic [31:0] slave_rd;
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;
  int last_acked = 2;
  logic [1:0] prev_ak = 2'b00;
  logic [31:0] sh0 = '0;
  logic [31:0] sh1 = '0;
  exp_t eq0[$], eq1[$];
  bus_t bq0[$], bq1[$];
  data_bus_arbiter #(.LOCK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .grant(grant), .data_bus_data(data_bus_data), .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
  always @(posedge clk) cyc <= cyc + 1;
  // Unwritten locations read back as C0DE plus the low address half
  assign data_bus_data = data_bus_mode == 2'b01 ? slave_rd : 'z;
  always_comb slave_rd = wr_flag[data_bus_addr[5:2]] ? mem[data_bus_addr[5:2]] : {16'hC0DE, data_bus_addr[15:0]};
  always @(posedge clk)
    if (clr) wr_flag <= '0;
    else if (data_bus_mode == 2'b10) begin
      mem[data_bus_addr[5:2]] <= data_bus_data;
      wr_flag[data_bus_addr[5:2]] <= 1'b1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic xfer(input int m, input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic lock, input logic [31:0] rd, input int lat, input int prev);
    exp_t e;
    bus_t b;
    logic legal, done;
    @(negedge clk);
    legal = mode == 2'b01 || mode == 2'b10;
    e.err = !legal;
    e.rdata = mode == 2'b01 ? rd : 32'h0;
    e.cyc = cyc + lat;
    e.prev = prev;
    b.mode = legal ? mode : 2'b00;
    b.addr = legal ? addr : 32'h0;
    b.data = wdata;
    if (m == 0) begin
      eq0.push_back(e); bq0.push_back(b);
      m0_mode = mode; m0_addr = addr; m0_wdata = wdata; m0_lock = lock; m0_req = 1'b1;
    end else begin
      eq1.push_back(e); bq1.push_back(b);
      m1_mode = mode; m1_addr = addr; m1_wdata = wdata; m1_lock = lock; m1_req = 1'b1;
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = m == 0 ? m0_ack : m1_ack;
    end
    chk("ack_arrived", done, 1'b1);
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask
  always @(negedge clk) begin : mon
    bus_t b;
    exp_t e;
    logic m;
    if (!reset) begin
      if (grant != 2'b00 && !m0_ack && !m1_ack) begin
        m = grant[1];
        chk("bus_grant", grant, m ? 2'b10 : 2'b01);
        if ((m ? bq1.size() : bq0.size()) == 0) chk("bus_unexpected", 1, 0);
        else begin
          if (m) b = bq1.pop_front();
          else b = bq0.pop_front();
          chk("bus_mode", data_bus_mode, b.mode);
          chk("bus_addr", data_bus_addr, b.addr);
          if (b.mode == 2'b10) chk("bus_wdata", data_bus_data, b.data);
        end
      end
      if (m0_ack || m1_ack) begin
        m = m1_ack;
        chk("ack_single", {m1_ack, m0_ack}, m ? 2'b10 : 2'b01);
        chk("ack_one_cycle", prev_ak, 2'b00);
        chk("done_grant", grant, m ? 2'b10 : 2'b01);
        chk("done_bus_idle", {data_bus_mode, data_bus_addr}, 34'h0);
        if ((m ? eq1.size() : eq0.size()) == 0) chk("ack_unexpected", 1, 0);
        else begin
          if (m) e = eq1.pop_front();
          else e = eq0.pop_front();
          chk(m ? "m1_err" : "m0_err", m ? m1_err : m0_err, e.err);
          chk(m ? "m1_rdata" : "m0_rdata", m ? m1_rdata : m0_rdata, e.rdata);
          chk("ack_cycle", cyc, e.cyc);
          if (e.prev != 2) chk("prev_master", last_acked, e.prev);
          chk("hold_other_rdata", m ? m0_rdata : m1_rdata, m ? sh0 : sh1);
          if (m) sh1 <= e.rdata;
          else sh0 <= e.rdata;
        end
        last_acked <= int'(m);
      end
      prev_ak <= {m1_ack, m0_ack};
    end
  end
  initial begin
    reset = 1'b1; clr = 1'b1;
    m0_req = 0; m0_lock = 0; m0_mode = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_mode = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_mode", data_bus_mode, 2'b00);
    chk("rst_addr", data_bus_addr, 32'h0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_m0_err", m0_err, 1'b0);
    chk("rst_m1_err", m1_err, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    clr = 1'b0;
    @(negedge clk); reset = 1'b0;
    // abort a write mid-BUS with an asynchronous reset
    @(negedge clk);
    m0_mode = 2'b10; m0_addr = 32'h40F0; m0_wdata = 32'h1111_1111; m0_req = 1'b1;
    @(posedge clk); #2;
    chk("abort_pre_mode", data_bus_mode, 2'b10);
    chk("abort_pre_grant", grant, 2'b01);
    reset = 1'b1; #1;
    chk("abort_mode", data_bus_mode, 2'b00);
    chk("abort_addr", data_bus_addr, 32'h0);
    chk("abort_grant", grant, 2'b00);
    chk("abort_acks", {m1_ack, m0_ack}, 2'b00);
    m0_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    // aborted write never landed, so the slave still returns its default pattern
    xfer(0, 2'b01, 32'h40F0, 0, 0, 32'hC0DE_40F0, 2, 2);
    xfer(0, 2'b10, 32'h40F0, 32'h0000_00A5, 0, 0, 2, 0);
    xfer(0, 2'b01, 32'h40F0, 0, 0, 32'h0000_00A5, 2, 0);
    // locked RMW by m1 keeps m0 out until the unlocking write completes
    fork
      begin
        xfer(1, 2'b01, 32'h40F0, 0, 1, 32'h0000_00A5, 2, 0);
        xfer(1, 2'b10, 32'h40F0, 32'h0000_00FF, 0, 0, 2, 1);
      end
      xfer(0, 2'b01, 32'h40F0, 0, 0, 32'h0000_00FF, 8, 1);
    join
    // continuous contention alternates 1,0,1,0,1,0 with acks 3 cycles apart
    fork
      begin
        xfer(1, 2'b01, 32'h40F0, 0, 0, 32'h0000_00FF, 2, 0);
        xfer(1, 2'b01, 32'h40F0, 0, 0, 32'h0000_00FF, 5, 0);
        xfer(1, 2'b01, 32'h40F0, 0, 0, 32'h0000_00FF, 5, 0);
      end
      begin
        xfer(0, 2'b10, 32'h1000, 32'h0000_00B0, 0, 0, 5, 1);
        xfer(0, 2'b10, 32'h1004, 32'h0000_00B1, 0, 0, 5, 1);
        xfer(0, 2'b10, 32'h1008, 32'h0000_00B2, 0, 0, 5, 1);
      end
    join
    xfer(1, 2'b11, 32'h40F0, 32'hDEAD_BEEF, 0, 0, 2, 0);
    xfer(0, 2'b00, 32'h40F0, 0, 0, 0, 2, 1);
    // m0 keeps the lock but goes idle: m1 waits out the 4-cycle timeout
    fork
      xfer(0, 2'b01, 32'h40F0, 0, 1, 32'h0000_00FF, 2, 0);
      begin
        repeat (3) @(negedge clk);
        xfer(1, 2'b01, 32'h1004, 0, 0, 32'h0000_00B1, 6, 0);
      end
    join
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", eq0.size() + eq1.size() + bq0.size() + bq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter and sequencer for the shared memory-mapped data bus (32-bit `data_bus_data` inout, 32-bit `data_bus_addr`, 2-bit `data_bus_mode`: 00 idle, 01 read, 10 write). It sits between the CPU load/store unit (master 0) and a second master such as a debug/DMA port (master 1), and is the only driver of the bus address and mode. It grants round-robin with an optional lock for atomic read-modify-write sequences, e.g. on the LED port at 0x40F0. It returns read data and a one-cycle ack to the winning master.

## Interface
- LOCK_TIMEOUT, 16: idle cycles after which an unused lock is forcibly released (≥1).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- mN_req  in  1  (N=0,1) transaction request; held with mode/addr/wdata/lock stable until mN_ack.
- mN_lock  in  1  keep exclusive ownership after this transaction.
- mN_mode  in  2  01 read, 10 write; 00/11 illegal.
- mN_addr  in  32  target address.
- mN_wdata  in  32  write data.
- mN_rdata  out  32  read data, registered, valid while mN_ack=1.
- mN_ack  out  1  one-cycle completion pulse.
- mN_err  out  1  with ack: illegal mode, no bus cycle issued.
- grant  out  2  one-hot owner during BUS/DONE, else 00.
- data_bus_data  inout  32  driven with wdata only in BUS for writes, else z.
- data_bus_addr  out  32  registered; 0 when not in BUS.
- data_bus_mode  out  2  registered; 00 when not in BUS.

## Operation
- FSM: IDLE → BUS → DONE → IDLE; only IDLE samples requests.
- IDLE: if any legal-or-illegal req, pick winner, latch its mode/addr/wdata into bus registers, go BUS; else stay.
- Winner selection: if lock owner set and owner requests → owner; if lock owner set and owner not requesting → nobody (other master waits); else if both request → master != last_winner; else sole requester.
- Illegal mode (00/11): bus registers stay idle (mode 00) through BUS; DONE asserts ack+err, rdata=0.
- BUS (1 cycle): mode/addr on bus; write drives data_bus_data. At end-of-cycle edge: read captures data_bus_data into winner's rdata; write sets rdata=0.
- DONE (1 cycle): winner's ack=1, bus idle, data z. last_winner←winner. If winner's lock=1, lock owner←winner; else lock owner cleared.
- Lock timeout: counter runs while lock owner set and owner's req=0 in IDLE; reaching LOCK_TIMEOUT clears owner and counter; counter reset on any owner grant.
- Non-winner acks, rdata hold value; rdata changes only for the winner.

## Timing
- Reset (async, immediate): state IDLE, grant 00, bus mode 00, addr 0, data z, all ack/err 0, all rdata 0, last_winner=1 (master 0 wins first tie), lock owner none, timeout counter 0.
- Latency: req visible at edge E0 → bus cycle between E1 and E2 → ack high E2..E3. Throughput one transaction per 3 cycles.
- Master must deassert or change req in the ack cycle; value at E3 starts a new arbitration.
- Simultaneous requests at IDLE with no lock: alternation strictly 0,1,0,1...
- Reset asserted during BUS: bus released same cycle; no ack for the aborted transaction.

## Structure
- Shared package/header `data_bus_defs`: mode constants BUS_IDLE=2'b00, BUS_READ=2'b01, BUS_WRITE=2'b10; FSM state encoding IDLE/BUS/DONE.
- Sub-module `rr_lock_picker`: combinational winner selection from req[1:0], last_winner, lock owner; FSM, bus registers, timeout counter stay in top.

## Test plan
- Reset: reset high mid-BUS write → immediately mode 00, data z, grant 00, acks 0; after release, m0 read of 0x40F0 completes with ack at E2.
- Single write then read: m0 writes 0x000000A5 to 0x40F0 (bus mode 10, addr 0x40F0, data 0xA5 for exactly one cycle), then reads → m0_rdata=0x000000A5 with ack.
- Contention: m0 and m1 request continuously → grants alternate 0,1,0,1; each ack 1 cycle; every ack 3 cycles apart.
- Lock RMW: m1 reads 0x40F0 with lock=1 while m0 requests; m1 then writes with lock=0 → m0 granted only after m1 write ack.
- Lock timeout (LOCK_TIMEOUT=4): m0 locked read then drops req, m1 requesting → m1 granted after 4 idle cycles, not before.
- Illegal mode: m1 req with mode 11 → bus mode stays 00, m1_ack=1 and m1_err=1, m1_rdata=0.
